wb_pipe_stage: RTL

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe_stage
// Brief    : MEM->WB pipeline register with a skid buffer. in_ready comes
//            straight from a flop, so out_ready has no combinational path
//            to it. Also produces write-back data/enable and a retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  // upstream (MEM) side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regw,
  input  logic               in_res_src,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_mem,
  input  logic [RADDR_W-1:0] in_rd,
  // downstream (WB) side
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_regw,
  output logic               out_res_src,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_mem,
  output logic [RADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_we,
  output logic [CNT_W-1:0]   retire_cnt
);

  // main entry (drives out_*)
  logic               main_valid_q, main_valid_d;
  logic               main_regw_q, main_regw_d;
  logic               main_src_q, main_src_d;
  logic [DATA_W-1:0]  main_alu_q, main_alu_d;
  logic [DATA_W-1:0]  main_mem_q, main_mem_d;
  logic [RADDR_W-1:0] main_rd_q, main_rd_d;
  // skid entry (holds the one entry accepted while main is stalled)
  logic               skid_valid_q, skid_valid_d;
  logic               skid_regw_q, skid_regw_d;
  logic               skid_src_q, skid_src_d;
  logic [DATA_W-1:0]  skid_alu_q, skid_alu_d;
  logic [DATA_W-1:0]  skid_mem_q, skid_mem_d;
  logic [RADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

  logic accept;
  logic consume;

  // A flushed cycle still lets the downstream consume, but never accepts.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid & in_ready & !flush;
  assign consume  = main_valid_q & out_ready;

  assign out_valid   = main_valid_q;
  assign out_regw    = main_regw_q;
  assign out_res_src = main_src_q;
  assign out_alu     = main_alu_q;
  assign out_mem     = main_mem_q;
  assign out_rd      = main_rd_q;
  assign wb_data     = main_src_q ? main_mem_q : main_alu_q;
  assign wb_we       = consume & main_regw_q & (main_rd_q != '0);
  assign retire_cnt  = retire_cnt_q;

  // Next-state: route input/skid into main or skid, keeping acceptance order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_regw_d  = main_regw_q;
    main_src_d   = main_src_q;
    main_alu_d   = main_alu_q;
    main_mem_d   = main_mem_q;
    main_rd_d    = main_rd_q;
    skid_valid_d = skid_valid_q;
    skid_regw_d  = skid_regw_q;
    skid_src_d   = skid_src_q;
    skid_alu_d   = skid_alu_q;
    skid_mem_d   = skid_mem_q;
    skid_rd_d    = skid_rd_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(consume);

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        // skid was full, so in_ready was low and nothing is accepted now
        main_valid_d = 1'b1;
        main_regw_d  = skid_regw_q;
        main_src_d   = skid_src_q;
        main_alu_d   = skid_alu_q;
        main_mem_d   = skid_mem_q;
        main_rd_d    = skid_rd_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_regw_d  = in_regw;
        main_src_d   = in_res_src;
        main_alu_d   = in_alu;
        main_mem_d   = in_mem;
        main_rd_d    = in_rd;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        // main is stalled: park the new entry in the skid register
        skid_valid_d = 1'b1;
        skid_regw_d  = in_regw;
        skid_src_d   = in_res_src;
        skid_alu_d   = in_alu;
        skid_mem_d   = in_mem;
        skid_rd_d    = in_rd;
      end else begin
        main_valid_d = 1'b1;
        main_regw_d  = in_regw;
        main_src_d   = in_res_src;
        main_alu_d   = in_alu;
        main_mem_d   = in_mem;
        main_rd_d    = in_rd;
      end
    end
  end

  // State registers with asynchronous reset clearing valids, payload and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_regw_q  <= 1'b0;
      main_src_q   <= 1'b0;
      main_alu_q   <= '0;
      main_mem_q   <= '0;
      main_rd_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_regw_q  <= 1'b0;
      skid_src_q   <= 1'b0;
      skid_alu_q   <= '0;
      skid_mem_q   <= '0;
      skid_rd_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_regw_q  <= main_regw_d;
      main_src_q   <= main_src_d;
      main_alu_q   <= main_alu_d;
      main_mem_q   <= main_mem_d;
      main_rd_q    <= main_rd_d;
      skid_valid_q <= skid_valid_d;
      skid_regw_q  <= skid_regw_d;
      skid_src_q   <= skid_src_d;
      skid_alu_q   <= skid_alu_d;
      skid_mem_q   <= skid_mem_d;
      skid_rd_q    <= skid_rd_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule
`default_nettype wire
